// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU controller: opcode and FSM state
// encodings plus bit positions of the {N,Z,C,V} flag nibble.
package alu_share_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB with {N,Z,C,V} flags.
// C is the carry-out for ADD and the borrow (a < b unsigned) for SUB;
// C and V are 0 for the logic operations.
module alu
    import alu_share_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  op_e             i_op,
    output logic [BITS-1:0] o_y,
    output logic [3:0]      o_flags
);

    logic [BITS:0] w_sum;
    logic [BITS:0] w_dif;
    logic          w_c;
    logic          w_v;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    // Select the result and the arithmetic flags for the requested operation
    always_comb begin
        o_y = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (i_op)
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_ADD: begin
                o_y = w_sum[BITS-1:0];
                w_c = w_sum[BITS];
                w_v = (i_a[BITS-1] == i_b[BITS-1]) && (w_sum[BITS-1] != i_a[BITS-1]);
            end
            OP_SUB: begin
                o_y = w_dif[BITS-1:0];
                w_c = w_dif[BITS];
                w_v = (i_a[BITS-1] != i_b[BITS-1]) && (w_dif[BITS-1] != i_a[BITS-1]);
            end
            default: o_y = '0;
        endcase
    end

    // Pack the flag nibble
    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = o_y[BITS-1];
        o_flags[FLAG_Z] = (o_y == '0);
        o_flags[FLAG_C] = w_c;
        o_flags[FLAG_V] = w_v;
    end

endmodule

// File: rtl/share_arbiter.sv
// Request arbiter for the shared ALU: picks one requester and returns a
// one-hot grant (qualified by i_en) plus its index.
// ALU_SHARE_RR_EN defined: round-robin, search starts at the rotating pointer.
// ALU_SHARE_RR_EN undefined: fixed priority, lowest index wins, no state.
module share_arbiter #(
    parameter  int NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
`ifdef ALU_SHARE_RR_EN
    input  logic             clk,
    input  logic             rst_n,
`endif
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_gidx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

`ifdef ALU_SHARE_RR_EN
    logic [IDX_W-1:0] r_ptr;

    // Circular search for the first active request starting at r_ptr
    always_comb begin
        int j;
        j       = 0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (!w_found && i_req[j]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(j);
            end
        end
    end

    // Advance the pointer past the winner whenever a grant is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_en && w_found) begin
            if (int'(w_idx) == NREQ - 1) r_ptr <= '0;
            else                         r_ptr <= w_idx + IDX_W'(1);
        end
    end
`else
    // Lowest active index wins
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(k);
            end
        end
    end
`endif

    assign o_any   = w_found;
    assign o_gidx  = w_idx;
    assign o_grant = (i_en && w_found) ? (NREQ'(1) << w_idx) : '0;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares a single ALU between NREQ requesters through a 3-state FSM
// (IDLE arbitrate -> EXEC compute -> RESP hold result until consumed).
// Optional macro ALU_SHARE_RR_EN selects round-robin instead of fixed
// priority arbitration.
// Operand and result registers are not reset; every output that carries
// them is forced to zero outside the state that makes it meaningful.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][BITS-1:0] req_a,
    input  logic [NREQ-1:0][BITS-1:0] req_b,
    input  logic [NREQ-1:0][1:0]      req_op,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [BITS-1:0]           rsp_y,
    output logic [3:0]                rsp_flags,
    output logic                      busy,
    output logic [CNT_W-1:0]          ops_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_ops;
    logic [BITS-1:0]  r_a;
    logic [BITS-1:0]  r_b;
    op_e              r_op;
    logic [BITS-1:0]  r_y;
    logic [3:0]       r_flags;

    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_gidx;
    logic             w_any;
    logic             w_arb_en;
    logic             w_accept;
    logic             w_hs;
    logic [BITS-1:0]  w_alu_y;
    logic [3:0]       w_alu_flags;

    // Grants only in IDLE; rst_n gating keeps req_ready low while reset is held
    assign w_arb_en = (r_state == S_IDLE) && rst_n;

    share_arbiter #(
        .NREQ   (NREQ)
    ) u_arb (
`ifdef ALU_SHARE_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .i_req  (req_valid),
        .i_en   (w_arb_en),
        .o_grant(w_grant),
        .o_gidx (w_gidx),
        .o_any  (w_any)
    );

    alu #(
        .BITS   (BITS)
    ) u_alu (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_op   (r_op),
        .o_y    (w_alu_y),
        .o_flags(w_alu_flags)
    );

    // Next-state and handshake outputs; defaults keep every output low
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_hs        = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_y       = '0;
        rsp_flags   = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = w_grant;
                if (w_any && w_arb_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = NREQ'(1) << r_owner;
                rsp_y     = r_y;
                rsp_flags = r_flags;
                if (rsp_ready[r_owner]) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM, response owner and completed-operation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ops   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_owner <= w_gidx;
            if (w_hs)     r_ops   <= r_ops + CNT_W'(1);
        end
    end

    // Datapath: capture operands on accept, capture ALU result once in EXEC
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a  <= req_a[w_gidx];
            r_b  <= req_b[w_gidx];
            r_op <= op_e'(req_op[w_gidx]);
        end
        if (r_state == S_EXEC) begin
            r_y     <= w_alu_y;
            r_flags <= w_alu_flags;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign ops_done = r_ops;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl (BITS=32, NREQ=2, CNT_W=4).
// Contention expectations follow ALU_SHARE_RR_EN the same way the design does.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int BITS  = 32;
    localparam int NREQ  = 2;
    localparam int CNT_W = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NREQ-1:0]           req_valid = '0;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][BITS-1:0] req_a = '0;
    logic [NREQ-1:0][BITS-1:0] req_b = '0;
    logic [NREQ-1:0][1:0]      req_op = '0;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_ready = '0;
    logic [BITS-1:0]           rsp_y;
    logic [3:0]                rsp_flags;
    logic                      busy;
    logic [CNT_W-1:0]          ops_done;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_ops = '0;

    always #5 clk = ~clk;

    alu_share_ctrl #(
        .BITS     (BITS),
        .NREQ     (NREQ),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_y    (rsp_y),
        .rsp_flags(rsp_flags),
        .busy     (busy),
        .ops_done (ops_done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Present one operation on requester idx and wait (bounded) for its grant;
    // returns at mid-cycle of EXEC with the request withdrawn.
    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b, input op_e op);
        int cyc;
        @(negedge clk);
        req_valid[idx] = 1'b1;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_op[idx]    = op;
        #1;
        cyc = 0;
        while (req_ready[idx] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("accept_ready", 64'(req_ready), 64'(onehot(idx)));
        @(posedge clk);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        check("exec_no_rsp", 64'(rsp_valid), 64'(0));
        check("exec_busy", 64'(busy), 64'(1));
    endtask

    // Expect the response in the next cycle, consume it and check the counter.
    task automatic get(input int idx, input logic [31:0] y, input logic [3:0] fl);
        @(negedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(onehot(idx)));
        check("rsp_y", 64'(rsp_y), 64'(y));
        check("rsp_flags", 64'(rsp_flags), 64'(fl));
        rsp_ready[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[idx] = 1'b0;
        exp_ops = exp_ops + 1'b1;
        #1;
        check("rsp_cleared", 64'(rsp_valid), 64'(0));
        check("ops_done", 64'(ops_done), 64'(exp_ops));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ops = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_seen[$];
        int hs;
        int cyc;
        logic [NREQ-1:0] last_grant;

        // Reset: outputs zero even with a request present
        req_valid = 2'b01;
        #2;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ops", 64'(ops_done), 64'(0));
        check("rst_y", 64'(rsp_y), 64'(0));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single operations
        send(0, 32'd5, 32'd3, OP_ADD);          get(0, 32'd8, 4'b0000);
        send(0, 32'd7, 32'd7, OP_SUB);          get(0, 32'd0, 4'b0100);
        send(0, 32'd3, 32'd5, OP_SUB);          get(0, 32'hFFFF_FFFE, 4'b1010);
        send(1, 32'h0000_F0F0, 32'h0000_FF00, OP_AND); get(1, 32'h0000_F000, 4'b0000);
        send(1, 32'd0, 32'd0, OP_OR);           get(1, 32'd0, 4'b0100);
        send(0, 32'h7FFF_FFFF, 32'd1, OP_ADD);  get(0, 32'h8000_0000, 4'b1001);
        send(1, 32'hFFFF_FFFF, 32'd1, OP_ADD);  get(1, 32'd0, 4'b0110);

        // Backpressure: result held, no grants while requester 1 waits
        send(0, 32'd10, 32'd20, OP_ADD);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_a[1]     = 32'hFFFF_0000;
        req_b[1]     = 32'h0F0F_0F0F;
        req_op[1]    = OP_AND;
        #1;
        check("bp_valid", 64'(rsp_valid), 64'(2'b01));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_y", 64'(rsp_y), 64'(32'd30));
            check("bp_flags", 64'(rsp_flags), 64'(4'b0000));
            check("bp_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check("bp_other_ready_ignored", 64'(rsp_valid), 64'(2'b01));
        check("bp_ops_hold", 64'(ops_done), 64'(exp_ops));
        get(0, 32'd30, 4'b0000);
        check("bp_waiter_granted", 64'(req_ready), 64'(2'b10));
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        get(1, 32'h0F0F_0000, 4'b0000);

        // Contention from reset: both requesters always valid, results always taken
        do_reset();
        req_valid = 2'b11;
        req_a[0] = 32'd1;  req_b[0] = 32'd2;  req_op[0] = OP_ADD;
        req_a[1] = 32'd10; req_b[1] = 32'd20; req_op[1] = OP_ADD;
        rsp_ready = 2'b11;
        last_grant = '0;
        hs = 0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready != '0) begin
                last_grant = req_ready;
                g_seen.push_back(req_ready == 2'b10 ? 1 : 0);
            end
            if (rsp_valid != '0) begin
                check("cont_owner", 64'(rsp_valid), 64'(last_grant));
                check("cont_y", 64'(rsp_y), (rsp_valid == 2'b01) ? 64'd3 : 64'd30);
                hs++;
            end
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = '0;
        check("cont_ngrants", 64'(g_seen.size()), 64'd4);
        check("cont_nrsp", 64'(hs), 64'd4);
        for (int i = 0; i < g_seen.size() && i < 4; i++) begin
`ifdef ALU_SHARE_RR_EN
            check("cont_grant_rr", 64'(g_seen[i]), 64'(i % 2));
`else
            check("cont_grant_fixed", 64'(g_seen[i]), 64'd0);
`endif
        end
        exp_ops = 4'd4;
        check("cont_ops", 64'(ops_done), 64'(exp_ops));

        // Reset during EXEC discards the transaction
        send(0, 32'd1, 32'd1, OP_ADD);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_ops", 64'(ops_done), 64'(0));
        check("mid_y", 64'(rsp_y), 64'(0));
        check("mid_flags", 64'(rsp_flags), 64'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ops = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mid_no_stale", 64'({busy, rsp_valid}), 64'(0));
        end

        // Counter wrap: 17 operations on a 4-bit counter
        req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = OP_ADD;
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        hs  = 0;
        cyc = 0;
        #1;
        while (hs < 17 && cyc < 200) begin
            if (rsp_valid[0]) begin
                hs++;
                if (hs == 17) begin
                    check("wrap_pre", 64'(ops_done), 64'(0));
                    req_valid = '0;
                end
            end
            if (hs < 17) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        check("wrap_count", 64'(hs), 64'd17);
        @(negedge clk);
        #1;
        rsp_ready = '0;
        check("wrap_ops", 64'(ops_done), 64'(1));
        check("wrap_idle", 64'({busy, rsp_valid}), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
